// File: rtl/x25519_pkg.sv
// Shared types, widths and helpers for the X25519 ladder sequencer.
// Optional scalar clamping is selected in the top with X25519_CLAMP_EN.
package x25519_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } ladder_state_t;

    localparam int FE_WIDTH     = 256;
    localparam int FE_PAD_WIDTH = 264;
    localparam int XZ_WIDTH     = 512;
    localparam int LADDER_BITS  = 255;

    // Projective point at infinity: x=1, z=0, packed {z, x}.
    localparam logic [XZ_WIDTH-1:0] XZ_ONE_INF = {256'h0, 256'h1};

    function automatic logic [FE_WIDTH-1:0] clamp_scalar(input logic [FE_WIDTH-1:0] s);
        logic [FE_WIDTH-1:0] r;
        r        = s;
        r[2:0]   = 3'b000;
        r[255]   = 1'b0;
        r[254]   = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/x25519_ladder_sequencer.sv
// Walks the Montgomery ladder over NBITS scalar bits, one iteration in flight at a time.
// Define X25519_CLAMP_EN to clamp the scalar as it is latched.
module x25519_ladder_sequencer
    import x25519_pkg::*;
#(
    parameter int NBITS = LADDER_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] scalar,
    input  logic [255:0] work_in,
    output logic         busy,
    output logic         done,
    output logic [511:0] xzm_result,
    output logic         iter_en,
    output logic [511:0] iter_xzm,
    output logic [511:0] iter_xzm1,
    output logic         iter_b,
    output logic [263:0] iter_work,
    input  logic         iter_out_valid,
    input  logic [511:0] iter_xzm_out,
    input  logic [511:0] iter_xzm1_out
);

    localparam logic [7:0] POS_FIRST = 8'(NBITS - 1);

    ladder_state_t       state_q, state_d;
    logic [FE_WIDTH-1:0] e_q, e_d;
    logic [FE_WIDTH-1:0] work_q, work_d;
    logic [XZ_WIDTH-1:0] xzm_q, xzm_d;
    logic [XZ_WIDTH-1:0] xzm1_q, xzm1_d;
    logic [XZ_WIDTH-1:0] xzm_result_q, xzm_result_d;
    logic [7:0]          pos_q, pos_d;
    logic                iter_b_q, iter_b_d;
    logic [FE_WIDTH-1:0] scalar_latch;

`ifdef X25519_CLAMP_EN
    assign scalar_latch = clamp_scalar(scalar);
`else
    assign scalar_latch = scalar;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            e_q          <= '0;
            work_q       <= '0;
            xzm_q        <= '0;
            xzm1_q       <= '0;
            xzm_result_q <= '0;
            pos_q        <= '0;
            iter_b_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            e_q          <= e_d;
            work_q       <= work_d;
            xzm_q        <= xzm_d;
            xzm1_q       <= xzm1_d;
            xzm_result_q <= xzm_result_d;
            pos_q        <= pos_d;
            iter_b_q     <= iter_b_d;
        end
    end

    // iter_b is only reloaded on the transition into ISSUE so the pipeline can re-sample it late.
    always_comb begin
        state_d      = state_q;
        e_d          = e_q;
        work_d       = work_q;
        xzm_d        = xzm_q;
        xzm1_d       = xzm1_q;
        xzm_result_d = xzm_result_q;
        pos_d        = pos_q;
        iter_b_d     = iter_b_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    e_d      = scalar_latch;
                    work_d   = work_in;
                    xzm_d    = XZ_ONE_INF;
                    xzm1_d   = {256'h1, work_in};
                    pos_d    = POS_FIRST;
                    iter_b_d = scalar_latch[NBITS-1];
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (iter_out_valid) begin
                    xzm_d  = iter_xzm_out;
                    xzm1_d = iter_xzm1_out;
                    if (pos_q == 8'd0) begin
                        xzm_result_d = iter_xzm_out;
                        state_d      = DONE;
                    end else begin
                        pos_d    = pos_q - 8'd1;
                        iter_b_d = e_q[pos_q - 8'd1];
                        state_d  = ISSUE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign iter_en    = (state_q == ISSUE);
    assign iter_xzm   = xzm_q;
    assign iter_xzm1  = xzm1_q;
    assign iter_b     = iter_b_q;
    assign iter_work  = {8'h0, work_q};
    assign xzm_result = xzm_result_q;

endmodule

// File: tb/tb_x25519_ladder_sequencer.sv
// Bench for the ladder sequencer: a latency-configurable ladder-step stub computes real
// field arithmetic mod 2^255-19; expected bits and results are queued at start and checked on output.
module tb_x25519_ladder_sequencer;

    localparam logic [255:0] P   = 256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
    localparam logic [255:0] A24 = 256'd121665;
    localparam logic [255:0] RFC_K = 256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4;
    localparam logic [255:0] RFC_U = 256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c;
    localparam logic [255:0] RFC_O = 256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] scalar = '0;
    logic [255:0] work_in = '0;
    logic         busy, done, iter_en, iter_b;
    logic [511:0] xzm_result, iter_xzm, iter_xzm1;
    logic [263:0] iter_work;
    logic         iter_out_valid = 1'b0;
    logic [511:0] iter_xzm_out = '0;
    logic [511:0] iter_xzm1_out = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 3;
    int pend = 0;
    int unstable = 0;
    logic         cap_b;
    logic [263:0] cap_work;
    logic [511:0] cap_xzm, cap_xzm1, res_xzm, res_xzm1;
    logic         exp_b_q[$];
    logic [511:0] exp_res_q[$];

    x25519_ladder_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .scalar(scalar), .work_in(work_in),
        .busy(busy), .done(done), .xzm_result(xzm_result),
        .iter_en(iter_en), .iter_xzm(iter_xzm), .iter_xzm1(iter_xzm1),
        .iter_b(iter_b), .iter_work(iter_work),
        .iter_out_valid(iter_out_valid), .iter_xzm_out(iter_xzm_out), .iter_xzm1_out(iter_xzm1_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [255:0] fred(input logic [511:0] a);
        logic [511:0] r;
        r = a % {256'h0, P};
        return r[255:0];
    endfunction

    function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
        return fred({256'h0, a} + {256'h0, b});
    endfunction

    function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
        return fred({256'h0, a} + {256'h0, P} - {256'h0, b});
    endfunction

    function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] aa, bb;
        aa = {256'h0, a};
        bb = {256'h0, b};
        return fred(aa * bb);
    endfunction

    function automatic logic [255:0] finv(input logic [255:0] z);
        logic [255:0] r, e;
        r = 256'h1;
        e = P - 256'd2;
        for (int i = 254; i >= 0; i--) begin
            r = fmul(r, r);
            if (e[i]) r = fmul(r, z);
        end
        return r;
    endfunction

    function automatic logic [255:0] bswap(input logic [255:0] a);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = a[8*(31-i) +: 8];
        return r;
    endfunction

    function automatic logic [255:0] bclamp(input logic [255:0] s);
        logic [255:0] one;
        one = 256'h1;
        return (s & ~(256'h7 | (one << 255))) | (one << 254);
    endfunction

    // One ladder iteration with swap in / swap out around the RFC 7748 step; returns {xzm1', xzm'}.
    function automatic logic [1023:0] lstep(input logic b, input logic [511:0] xzm,
                                            input logic [511:0] xzm1, input logic [255:0] u);
        logic [255:0] x1, x2, z2, x3, z3, t, a, aa, bv, bb, e, c, d, da, cb, nx2, nz2, nx3, nz3;
        x1 = fred({256'h0, u});
        x2 = fred({256'h0, xzm[255:0]});
        z2 = fred({256'h0, xzm[511:256]});
        x3 = fred({256'h0, xzm1[255:0]});
        z3 = fred({256'h0, xzm1[511:256]});
        if (b) begin
            t = x2; x2 = x3; x3 = t;
            t = z2; z2 = z3; z3 = t;
        end
        a   = fadd(x2, z2);  aa = fmul(a, a);
        bv  = fsub(x2, z2);  bb = fmul(bv, bv);
        e   = fsub(aa, bb);
        c   = fadd(x3, z3);  d  = fsub(x3, z3);
        da  = fmul(d, a);    cb = fmul(c, bv);
        t   = fadd(da, cb);  nx3 = fmul(t, t);
        t   = fsub(da, cb);  nz3 = fmul(x1, fmul(t, t));
        nx2 = fmul(aa, bb);
        nz2 = fmul(e, fadd(aa, fmul(A24, e)));
        if (b) return {nz2, nx2, nz3, nx3};
        return {nz3, nx3, nz2, nx2};
    endfunction

    function automatic logic [511:0] model(input logic [255:0] e, input logic [255:0] u);
        logic [511:0] xzm, xzm1;
        logic [1023:0] r;
        xzm  = {256'h0, 256'h1};
        xzm1 = {256'h1, u};
        for (int i = 254; i >= 0; i--) begin
            r    = lstep(e[i], xzm, xzm1, u);
            xzm  = r[511:0];
            xzm1 = r[1023:512];
        end
        return xzm;
    endfunction

    // Behavioural iteration pipeline: result appears lat cycles after the issue strobe.
    always @(negedge clk) begin
        logic [1023:0] r;
        logic eb;
        iter_out_valid = 1'b0;
        if (pend > 0) begin
            if (iter_b !== cap_b || iter_work !== cap_work || iter_xzm !== cap_xzm || iter_xzm1 !== cap_xzm1)
                unstable++;
            pend--;
            if (pend == 0) begin
                iter_out_valid = 1'b1;
                iter_xzm_out   = res_xzm;
                iter_xzm1_out  = res_xzm1;
            end
        end
        if (iter_en === 1'b1) begin
            cap_b    = iter_b;
            cap_work = iter_work;
            cap_xzm  = iter_xzm;
            cap_xzm1 = iter_xzm1;
            pend     = lat;
            if (exp_b_q.size() > 0) begin
                eb = exp_b_q.pop_front();
                chk("iter_b_seq", {511'h0, iter_b}, {511'h0, eb});
            end
            r        = lstep(iter_b, iter_xzm, iter_xzm1, iter_work[255:0]);
            res_xzm  = r[511:0];
            res_xzm1 = r[1023:512];
        end
    end

    function automatic logic [255:0] dut_scalar(input logic [255:0] s);
`ifdef X25519_CLAMP_EN
        return bclamp(s);
`else
        return s;
`endif
    endfunction

    task automatic do_run(input logic [255:0] sc, input logic [255:0] wk, input int l,
                          input bit disturb, output logic [511:0] res);
        int s, n_en, first_en, done_cyc;
        logic [255:0] e_exp;
        logic [511:0] er;
        lat   = l;
        e_exp = dut_scalar(sc);
        for (int i = 254; i >= 0; i--) exp_b_q.push_back(e_exp[i]);
        exp_res_q.push_back(model(e_exp, wk));
        @(negedge clk);
        start = 1'b1; scalar = sc; work_in = wk; s = cyc;
        n_en = 0; first_en = -1; done_cyc = -1; unstable = 0;
        for (int k = 0; k < 260 * (l + 1) + 20 && done_cyc < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (disturb && (cyc == s + 5 || cyc == s + 500)) begin
                start = 1'b1; scalar = ~sc; work_in = ~wk;
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                chk("busy_at_done", {511'h0, busy}, {511'h0, 1'b1});
                if (disturb) start = 1'b1;
            end
            if (iter_en === 1'b1) begin
                if (first_en < 0) first_en = cyc;
                n_en++;
                if (disturb && n_en == 3) begin
                    #1;
                    iter_out_valid = 1'b1;
                    iter_xzm_out   = {16{32'hdeadbeef}};
                    iter_xzm1_out  = {16{32'hcafef00d}};
                end
            end
        end
        chk("done_cycle", done_cyc - s, 255 * (l + 1) + 1);
        chk("first_iter_en", first_en - s, 1);
        chk("iter_en_count", n_en, 255);
        chk("operand_stable", unstable, 0);
        chk("bits_drained", exp_b_q.size(), 0);
        exp_b_q.delete();
        er = exp_res_q.pop_front();
        chk("xzm_result", xzm_result, er);
        res = xzm_result;
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", {511'h0, done}, 512'h0);
        chk("idle_after_done", {511'h0, busy}, 512'h0);
        chk("result_held", xzm_result, er);
    endtask

    initial begin
        logic [511:0] r;
        logic [255:0] e5, k3, u3;
        int s;

        start = 1'b1; scalar = '1; work_in = '1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {511'h0, busy}, 512'h0);
        chk("rst_done", {511'h0, done}, 512'h0);
        chk("rst_iter_en", {511'h0, iter_en}, 512'h0);
        chk("rst_iter_b", {511'h0, iter_b}, 512'h0);
        chk("rst_xzm_result", xzm_result, 512'h0);
        chk("rst_iter_xzm", iter_xzm, 512'h0);
        chk("rst_iter_xzm1", iter_xzm1, 512'h0);
        chk("rst_iter_work", {248'h0, iter_work}, 512'h0);
        rst = 1'b0; start = 1'b0;

        // zero scalar, L=3
        do_run(256'h0, 256'd9, 3, 1'b0, r);
`ifndef X25519_CLAMP_EN
        chk("t1_infinity", r, {256'h0, 256'h1});
`endif

        // alternating scalar bits, L=1
        do_run({32{8'h5A}}, 256'd9, 1, 1'b0, r);

        // RFC 7748 vector, scalar clamped and u top bit masked as the caller would
        k3 = bclamp(bswap(RFC_K));
        u3 = bswap(RFC_U);
        u3[255] = 1'b0;
        do_run(k3, u3, 2, 1'b0, r);
        chk("rfc7748_u_out", {256'h0, fmul(r[255:0], finv(fred({256'h0, r[511:256]})))},
            {256'h0, bswap(RFC_O)});

        // extra starts at +5, +500 and in the done cycle, plus a stray result strobe during ISSUE
        do_run(256'h0, 256'd9, 3, 1'b1, r);

        // reset 200 cycles into a run
        lat = 4;
        e5  = dut_scalar({32{8'h5A}});
        for (int i = 254; i >= 0; i--) exp_b_q.push_back(e5[i]);
        @(negedge clk);
        start = 1'b1; scalar = {32{8'h5A}}; work_in = 256'd9; s = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {511'h0, busy}, 512'h0);
        chk("midrst_iter_en", {511'h0, iter_en}, 512'h0);
        chk("midrst_xzm_result", xzm_result, 512'h0);
        exp_b_q.delete();
        repeat (10) @(negedge clk);
        chk("late_valid_busy", {511'h0, busy}, 512'h0);
        chk("late_valid_result", xzm_result, 512'h0);
        do_run({32{8'h5A}}, 256'd9, 4, 1'b0, r);

        // all-ones scalar; clamping shows up in the first and last three bits
        do_run({256{1'b1}}, 256'd9, 3, 1'b0, r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
